// File: rtl/collatz_engine.sv
// Width-generic sequential Collatz iterator: one step per enabled clock,
// with step count, running peak and zero/overflow/step-saturation detection.
module collatz_engine #(
    parameter int WIDTH     = 13,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     start_value,
    input  logic                 pause_sw,
    output logic [WIDTH-1:0]     value,
    output logic [CNT_WIDTH-1:0] steps,
    output logic [WIDTH-1:0]     peak,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic                 zero_in,
    output logic                 step_sat
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    localparam int XW = WIDTH + 2;

    state_t               r_state;
    logic [WIDTH-1:0]     r_value;
    logic [WIDTH-1:0]     r_peak;
    logic [CNT_WIDTH-1:0] r_steps;
    logic                 r_ovf;
    logic                 r_zero;
    logic                 r_sat;

    logic [XW-1:0]        w_ext;
    logic [XW-1:0]        w_next;
    logic [WIDTH-1:0]     w_next_val;
    logic                 w_too_big;
    logic                 w_is_one;
    logic                 w_cnt_full;
    logic                 w_seed_zero;

    // 3n+1 needs two guard bits: 3*(2^W-1)+1 < 2^(W+2)
    assign w_ext       = {2'b00, r_value};
    assign w_next      = r_value[0] ? (w_ext + (w_ext << 1) + XW'(1))
                                    : (w_ext >> 1);
    assign w_next_val  = w_next[WIDTH-1:0];
    assign w_too_big   = |w_next[XW-1:WIDTH];
    assign w_is_one    = (r_value == WIDTH'(1));
    assign w_cnt_full  = &r_steps;
    assign w_seed_zero = (start_value == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_value <= '0;
            r_peak  <= '0;
            r_steps <= '0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (!pause_sw) begin
                        if (w_is_one) begin
                            r_state <= S_DONE;
                        end else if (w_cnt_full) begin
                            r_state <= S_ERR;
                            r_sat   <= 1'b1;
                        end else if (w_too_big) begin
                            // value keeps the last legal operand
                            r_state <= S_ERR;
                            r_ovf   <= 1'b1;
                        end else begin
                            r_value <= w_next_val;
                            r_steps <= r_steps + CNT_WIDTH'(1);
                            if (w_next_val > r_peak) begin
                                r_peak <= w_next_val;
                            end
                        end
                    end
                end
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_value <= start_value;
                        r_peak  <= start_value;
                        r_steps <= '0;
                        r_ovf   <= 1'b0;
                        r_sat   <= 1'b0;
                        r_zero  <= w_seed_zero;
                        r_state <= w_seed_zero ? S_ERR : S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign value    = r_value;
    assign steps    = r_steps;
    assign peak     = r_peak;
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign overflow = (r_state == S_ERR) && r_ovf;
    assign zero_in  = (r_state == S_ERR) && r_zero;
    assign step_sat = (r_state == S_ERR) && r_sat;

endmodule

// File: tb/tb_collatz_engine.sv
// Self-checking bench: three engine configurations driven in parallel
// and compared against an arithmetic Collatz reference model.
module tb_collatz_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pause_sw;
    logic [13:0] sv;

    logic [12:0] v0, p0;
    logic [7:0]  s0;
    logic        b0, d0, o0, z0, q0;
    logic [12:0] v1, p1;
    logic [3:0]  s1;
    logic        b1, d1, o1, z1, q1;
    logic [13:0] v2, p2;
    logic [7:0]  s2;
    logic        b2, d2, o2, z2, q2;

    int checks   = 0;
    int failures = 0;

    longint ov[3], os[3], op[3];
    bit     ob[3], od[3], oo[3], oz[3], oq[3];
    int     lat[3];
    int     WS[3] = '{13, 13, 14};
    int     CS[3] = '{8, 4, 8};

    always #5 clk = ~clk;

    collatz_engine #(.WIDTH(13), .CNT_WIDTH(8)) u0 (
        .clk(clk), .reset(reset), .start(start),
        .start_value(sv[12:0]), .pause_sw(pause_sw),
        .value(v0), .steps(s0), .peak(p0), .busy(b0), .done(d0),
        .overflow(o0), .zero_in(z0), .step_sat(q0)
    );

    collatz_engine #(.WIDTH(13), .CNT_WIDTH(4)) u1 (
        .clk(clk), .reset(reset), .start(start),
        .start_value(sv[12:0]), .pause_sw(pause_sw),
        .value(v1), .steps(s1), .peak(p1), .busy(b1), .done(d1),
        .overflow(o1), .zero_in(z1), .step_sat(q1)
    );

    collatz_engine #(.WIDTH(14), .CNT_WIDTH(8)) u2 (
        .clk(clk), .reset(reset), .start(start),
        .start_value(sv), .pause_sw(pause_sw),
        .value(v2), .steps(s2), .peak(p2), .busy(b2), .done(d2),
        .overflow(o2), .zero_in(z2), .step_sat(q2)
    );

    // Reference: walk the sequence with plain arithmetic.
    // lat = clock edges after the load edge until the final state shows.
    function automatic void ref_run(
        input  longint seed, input int w, input int c,
        output longint v, output longint st, output longint pk,
        output int lat_o, output bit dn, output bit ovf,
        output bit sat, output bit zr);
        longint maxv, maxc, nx;
        maxv = (longint'(1) << w) - 1;
        maxc = (longint'(1) << c) - 1;
        dn = 0; ovf = 0; sat = 0; zr = 0; lat_o = 0;
        v = seed; st = 0; pk = seed;
        if (seed == 0) begin
            zr = 1;
            return;
        end
        while (1) begin
            lat_o++;
            if (v == 1) begin
                dn = 1;
                break;
            end
            if (st == maxc) begin
                sat = 1;
                break;
            end
            nx = (v % 2 == 1) ? 3 * v + 1 : v / 2;
            if (nx > maxv) begin
                ovf = 1;
                break;
            end
            v = nx;
            st++;
            if (nx > pk) pk = nx;
        end
    endfunction

    task automatic snap();
        ov[0] = v0; os[0] = s0; op[0] = p0;
        ob[0] = b0; od[0] = d0; oo[0] = o0; oz[0] = z0; oq[0] = q0;
        ov[1] = v1; os[1] = s1; op[1] = p1;
        ob[1] = b1; od[1] = d1; oo[1] = o1; oz[1] = z1; oq[1] = q1;
        ov[2] = v2; os[2] = s2; op[2] = p2;
        ob[2] = b2; od[2] = d2; oo[2] = o2; oz[2] = z2; oq[2] = q2;
    endtask

    // Load a seed, optionally pause for pl edges from edge ps, optionally
    // pulse start at edge inj; record per-DUT latency until busy drops.
    task automatic launch(input longint seed, input int ps,
                          input int pl, input int inj);
        int n;
        bit fin[3];
        sv       = seed[13:0];
        pause_sw = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        snap();
        for (int i = 0; i < 3; i++) begin
            fin[i] = !ob[i];
            lat[i] = ob[i] ? -1 : 0;
        end
        while (!(fin[0] && fin[1] && fin[2]) && n < 2000) begin
            pause_sw = (ps >= 0) && (n >= ps) && (n < ps + pl);
            if (n == inj) begin
                start = 1'b1;
                sv    = 14'd100;
            end
            @(posedge clk);
            #1 start = 1'b0;
            n++;
            snap();
            for (int i = 0; i < 3; i++) begin
                if (!fin[i] && !ob[i]) begin
                    fin[i] = 1;
                    lat[i] = n;
                end
            end
        end
        pause_sw = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pause_sw = 1'b0; sv = '0;
        repeat (3) @(posedge clk);
        #1 snap();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ov[i], os[i], op[i]} !== 192'd0 ||
                {ob[i], od[i], oo[i], oz[i], oq[i]} !== 5'd0) begin
                failures++;
                $display("FAIL reset dut%0d: v=%0d s=%0d p=%0d flags=%b%b%b%b%b want all 0",
                         i, ov[i], os[i], op[i], ob[i], od[i], oo[i], oz[i], oq[i]);
            end
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors();
        longint seeds[5] = '{6, 7, 27, 1, 0};
        longint ev, es, ep;
        int     el;
        bit     ed, eo, ea, ez;
        for (int k = 0; k < 5; k++) begin
            launch(seeds[k], -1, 0, -1);
            for (int i = 0; i < 3; i++) begin
                ref_run(seeds[k], WS[i], CS[i], ev, es, ep, el, ed, eo, ea, ez);
                checks++;
                if (lat[i] !== el) begin
                    failures++;
                    $display("FAIL vec_latency seed=%0d dut%0d: got %0d want %0d",
                             seeds[k], i, lat[i], el);
                end
                checks++;
                if ({ov[i], os[i], op[i]} !== {ev, es, ep}) begin
                    failures++;
                    $display("FAIL vec_data seed=%0d dut%0d: v/s/p=%0d/%0d/%0d want %0d/%0d/%0d",
                             seeds[k], i, ov[i], os[i], op[i], ev, es, ep);
                end
                checks++;
                if ({ob[i], od[i], oo[i], oz[i], oq[i]} !== {1'b0, ed, eo, ez, ea}) begin
                    failures++;
                    $display("FAIL vec_flags seed=%0d dut%0d: bdozs=%b%b%b%b%b want 0%b%b%b%b",
                             seeds[k], i, ob[i], od[i], oo[i], oz[i], oq[i], ed, eo, ez, ea);
                end
            end
            if (seeds[k] == 27) begin
                checks++;
                if (!(oo[0] && ov[0] == 3077 && os[0] == 76 && op[0] == 7288)) begin
                    failures++;
                    $display("FAIL known27_w13: ovf=%b v=%0d s=%0d p=%0d want 1/3077/76/7288",
                             oo[0], ov[0], os[0], op[0]);
                end
                checks++;
                if (!(od[2] && os[2] == 111 && op[2] == 9232)) begin
                    failures++;
                    $display("FAIL known27_w14: done=%b s=%0d p=%0d want 1/111/9232",
                             od[2], os[2], op[2]);
                end
            end
            if (seeds[k] == 7) begin
                checks++;
                if (!(oq[1] && ov[1] == 2 && os[1] == 15)) begin
                    failures++;
                    $display("FAIL known7_cnt4: sat=%b v=%0d s=%0d want 1/2/15",
                             oq[1], ov[1], os[1]);
                end
                checks++;
                if (!(od[0] && os[0] == 16 && op[0] == 52)) begin
                    failures++;
                    $display("FAIL known7: done=%b s=%0d p=%0d want 1/16/52",
                             od[0], os[0], op[0]);
                end
            end
            if (seeds[k] == 6) begin
                checks++;
                if (!(lat[0] == 9 && od[0] && ov[0] == 1 && os[0] == 8 && op[0] == 16)) begin
                    failures++;
                    $display("FAIL known6: lat=%0d done=%b v=%0d s=%0d p=%0d want 9/1/1/8/16",
                             lat[0], od[0], ov[0], os[0], op[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        longint seed, ev, es, ep;
        int     el;
        bit     ed, eo, ea, ez;
        for (int k = 0; k < 10; k++) begin
            seed = longint'($urandom_range(1, 8191));
            launch(seed, -1, 0, -1);
            for (int i = 0; i < 3; i++) begin
                ref_run(seed, WS[i], CS[i], ev, es, ep, el, ed, eo, ea, ez);
                checks++;
                if (lat[i] !== el ||
                    {ov[i], os[i], op[i]} !== {ev, es, ep} ||
                    {ob[i], od[i], oo[i], oz[i], oq[i]} !== {1'b0, ed, eo, ez, ea}) begin
                    failures++;
                    $display("FAIL rand seed=%0d dut%0d: lat=%0d v=%0d s=%0d p=%0d f=%b%b%b%b want lat=%0d v=%0d s=%0d p=%0d f=%b%b%b%b",
                             seed, i, lat[i], ov[i], os[i], op[i], od[i], oo[i], oz[i], oq[i],
                             el, ev, es, ep, ed, eo, ez, ea);
                end
            end
        end
    endtask

    task automatic test_pause();
        longint ev, es, ep;
        int     el;
        bit     ed, eo, ea, ez;
        // pause 5 edges mid-run and pulse start (with a new seed) in RUN
        launch(6, 3, 5, 6);
        for (int i = 0; i < 3; i++) begin
            ref_run(6, WS[i], CS[i], ev, es, ep, el, ed, eo, ea, ez);
            checks++;
            if (lat[i] !== el + 5) begin
                failures++;
                $display("FAIL pause_latency dut%0d: got %0d want %0d", i, lat[i], el + 5);
            end
            checks++;
            if ({ov[i], os[i], op[i]} !== {ev, es, ep} || od[i] !== ed) begin
                failures++;
                $display("FAIL pause_data dut%0d: v/s/p/d=%0d/%0d/%0d/%b want %0d/%0d/%0d/%b",
                         i, ov[i], os[i], op[i], od[i], ev, es, ep, ed);
            end
        end
    endtask

    task automatic test_reset_midrun();
        longint ev, es, ep;
        int     el;
        bit     ed, eo, ea, ez;
        sv    = 14'd27;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1 snap();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ov[i], os[i], op[i]} !== 192'd0 ||
                {ob[i], od[i], oo[i], oz[i], oq[i]} !== 5'd0) begin
                failures++;
                $display("FAIL async_reset dut%0d: v=%0d s=%0d p=%0d flags=%b%b%b%b%b want all 0",
                         i, ov[i], os[i], op[i], ob[i], od[i], oo[i], oz[i], oq[i]);
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        launch(6, -1, 0, -1);
        for (int i = 0; i < 3; i++) begin
            ref_run(6, WS[i], CS[i], ev, es, ep, el, ed, eo, ea, ez);
            checks++;
            if (lat[i] !== el || {ov[i], os[i], op[i]} !== {ev, es, ep} || od[i] !== ed) begin
                failures++;
                $display("FAIL after_reset dut%0d: lat=%0d v=%0d s=%0d p=%0d d=%b want %0d/%0d/%0d/%0d/%b",
                         i, lat[i], ov[i], os[i], op[i], od[i], el, ev, es, ep, ed);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        sv    = 14'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        #1 snap();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!(ob[i] && os[i] == 4)) begin
                failures++;
                $display("FAIL held_start_run dut%0d: busy=%b s=%0d want 1/4", i, ob[i], os[i]);
            end
        end
        repeat (5) @(posedge clk);
        #1 snap();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!(od[i] && ov[i] == 1 && os[i] == 8 && op[i] == 16)) begin
                failures++;
                $display("FAIL held_start_done dut%0d: d=%b v=%0d s=%0d p=%0d want 1/1/8/16",
                         i, od[i], ov[i], os[i], op[i]);
            end
        end
        @(posedge clk);
        #1 snap();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!(ob[i] && !od[i] && ov[i] == 6 && os[i] == 0 && op[i] == 6)) begin
                failures++;
                $display("FAIL reload dut%0d: b=%b d=%b v=%0d s=%0d p=%0d want 1/0/6/0/6",
                         i, ob[i], od[i], ov[i], os[i], op[i]);
            end
        end
        n = 0;
        while (b0 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (!(d0 && n == 9)) begin
            failures++;
            $display("FAIL reload_finish: done=%b edges=%0d want 1/9", d0, n);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_pause();
        test_reset_midrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/collatz_engine.md
# collatz_engine

Parametrised sequential Collatz iterator: loads a start value, then applies one step per enabled clock (n/2 if even, 3n+1 if odd) until the value reaches 1. Counts steps and tracks the running peak. Detects zero input, arithmetic overflow and step-counter saturation. It sits between the switch/start front end and the display logic, replacing the free-running enable-bit/adder datapath with a controlled, width-generic engine.

## Interface
- WIDTH, 13: datapath width of value, start_value and peak.
- CNT_WIDTH, 8: width of the step counter.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  load request; honoured only in IDLE, DONE or ERR.
- start_value  in  WIDTH  sequence seed, sampled on an honoured start.
- pause_sw  in  1  freezes iteration while high (RUN only).
- value  out  WIDTH  current sequence value.
- steps  out  CNT_WIDTH  steps applied since load.
- peak  out  WIDTH  maximum value since load, including the seed.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; value==1.
- overflow  out  1  high in ERR when 3n+1 exceeded 2^WIDTH-1.
- zero_in  out  1  high in ERR when the seed was 0.
- step_sat  out  1  high in ERR when the step counter would wrap.

## Operation
- States: IDLE (reset state), RUN, DONE, ERR. busy, done and error flags decode directly from state and cause registers.
- IDLE/DONE/ERR + start: value<=start_value, steps<=0, peak<=start_value, and all flags clear.
  - Seed nonzero -> RUN.
  - Seed 0 -> ERR with zero_in=1.
- IDLE/DONE/ERR without start: hold all outputs.
- RUN, pause_sw=1: hold everything. start is ignored throughout RUN.
- RUN, pause_sw=0, value==1: -> DONE; no step is applied.
- RUN, pause_sw=0, value!=1:
  - If steps==2^CNT_WIDTH-1: -> ERR with step_sat=1; value, steps and peak unchanged.
  - Else compute next. Even: value>>1. Odd: 3*value+1, evaluated at WIDTH+2 bits.
  - If next > 2^WIDTH-1: -> ERR with overflow=1; value, steps and peak unchanged, so value shows the last legal operand.
  - Else value<=next, steps<=steps+1, peak<=max(peak,next).
- Priority within RUN: pause > done check > step_sat > overflow > normal step.
- reset at any time, including mid-RUN: state=IDLE, and value, steps, peak and all flags are 0.

## Timing
- Reset values: value=0, steps=0, peak=0, busy=0, done=0, overflow=0, zero_in=0, step_sat=0.
- start sampled at rising edge k:
  - Outputs reflect the loaded seed after edge k.
  - busy=1 from edge k (nonzero seed).
- One step per unpaused RUN cycle.
- For a seed with S total steps and no pause: done rises after edge k+S+1, and busy falls at the same edge.
- ERR entry happens at the edge that would have performed the offending step.
- A pause of P cycles delays completion by exactly P cycles, with no other effect.
- start held high across DONE -> a reload occurs on the first edge in DONE/ERR, then is ignored in RUN.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=13, start_value=6, pause_sw=0 -> after 9 edges post-start: done=1, value=1, steps=8, peak=16.
- start_value=7 -> done with steps=16, peak=52. Repeat with CNT_WIDTH=4 -> ERR, step_sat=1, value=2, steps=15.
- WIDTH=13, start_value=27 -> ERR, overflow=1, value=3077, steps=76, peak=7288. WIDTH=14, start_value=27 -> done, steps=111, peak=9232.
- start_value=0 -> ERR, zero_in=1, busy never asserted. start_value=1 -> done one edge after load, steps=0, peak=1.
- start_value=6 with pause_sw high for 5 cycles mid-run -> done exactly 5 cycles later than unpaused, same steps and peak. A start pulse during RUN has no effect.
- reset asserted asynchronously mid-RUN (start_value=27) -> all outputs 0 immediately, state IDLE. A new start of 6 then completes normally.
